// File: rtl/bidir_pio_pkg.sv
// Shared constants for the bidirectional PIO: register addresses, edge
// capture modes and parameter limits.
package bidir_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;

endpackage

// File: rtl/bidir_pio_sync.sv
// Input synchroniser chain for the PIO pins, with one extra "previous" stage
// used to form the per-bit edge-event vector selected by EDGE_TYPE.
module bidir_pio_sync
  import bidir_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] edge_evt
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev_p;
  logic             armed;
  logic [WIDTH-1:0] raw_evt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev_p <= '0;
      armed  <= 1'b0;
    end else begin
      sync_p[0] <= pin;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev_p <= sync_p[SYNC_STAGES-1];
      armed  <= 1'b1;
    end
  end

  assign sync_val = sync_p[SYNC_STAGES-1];

  always_comb begin
    raw_evt = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  raw_evt = sync_val & ~prev_p;
      EDGE_FALLING: raw_evt = ~sync_val & prev_p;
      default:      raw_evt = sync_val ^ prev_p;
    endcase
  end

  // No events in the first cycle out of reset, whatever the pins are doing.
  assign edge_evt = armed ? raw_evt : '0;

endmodule

// File: rtl/bidir_pio_n.sv
// WIDTH-bit bidirectional PIO Avalon-MM slave with atomic set/clear and edge IRQs.
// Define BIDIR_PIO_OPEN_DRAIN_EN for open-drain pins (default: push-pull).
module bidir_pio_n
  import bidir_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter bit RESET_DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;

  bidir_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (bidir_port),
    .sync_val(sync_val),
    .edge_evt(edge_evt)
  );

  assign wr_en   = chipselect && !write_n;
  assign cap_clr = (wr_en && (address == ADDR_EDGECAP)) ? writedata : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = sync_val;
      ADDR_DIR:     rd_mux = dir;
      ADDR_IRQMASK: rd_mux = irq_mask;
      ADDR_EDGECAP: rd_mux = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= '0;
      dir      <= {WIDTH{RESET_DIR}};
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      // A new event overrides a same-cycle write-1-to-clear.
      edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
      if (wr_en) begin
        case (address)
          ADDR_DATA:    data_out <= writedata;
          ADDR_DIR:     dir      <= writedata;
          ADDR_IRQMASK: irq_mask <= writedata;
          ADDR_OUTSET:  data_out <= data_out | writedata;
          ADDR_OUTCLR:  data_out <= data_out & ~writedata;
          default:      ;
        endcase
      end
    end
  end

  assign irq = |(edge_cap & irq_mask);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef BIDIR_PIO_OPEN_DRAIN_EN
    assign bidir_port[i] = (dir[i] && !data_out[i]) ? 1'b0 : 1'bz;
`else
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
`endif
  end

endmodule
